// File: rtl/alu_bank_if.sv
// Command/response bundle for alu_bank: valid/ready command in, status out.
interface alu_bank_if #(
  parameter int WIDTH = 8,
  parameter int NACC  = 4
);
  localparam int SW = $clog2(NACC);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       control;
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] acc_out;
  logic [3:0]       flags;
  logic             done;

  modport master (
    output in_valid, control, sel, in,
    input  in_ready, acc_out, flags, done
  );

  modport slave (
    input  in_valid, control, sel, in,
    output in_ready, acc_out, flags, done
  );
endinterface

// File: rtl/alu_bank.sv
// Multi-accumulator ALU: NACC accumulators, single-cycle ops plus
// iterative shift (one bit/cycle) and shift-add multiply (WIDTH cycles).

// One accumulator register with write enable.
module alu_bank_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // Clear on reset, load on write enable.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module alu_bank #(
  parameter int WIDTH = 8,
  parameter int NACC  = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_bank_if.slave  bus
);
  localparam int SW = $clog2(NACC);
  localparam int KW = $clog2(WIDTH);
  localparam int CW = KW + 1;
  localparam int M  = WIDTH - 1;

  localparam logic [3:0] OP_HOLD  = 4'd0;
  localparam logic [3:0] OP_CLEAR = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_NEG   = 4'd5;
  localparam logic [3:0] OP_NOT   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_ADC   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t state_q, state_nxt;

  logic [NACC-1:0][WIDTH-1:0] acc_q;
  logic [NACC-1:0]            acc_we;
  logic                       wr_en;
  logic [SW-1:0]              wr_sel;
  logic [WIDTH-1:0]           wr_data;

  logic [SW-1:0] sel_q;
  logic [3:0]    flags_q, flags_nxt;
  logic          flags_we;
  logic          done_q, fin;
  logic          ready, accept;

  // Working registers for iterative ops. lo_q doubles as the shifter.
  logic [WIDTH-1:0] lo_q, hi_q, mcand_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_left_q;
  logic             last;

  logic [WIDTH-1:0] a_op, b_op;
  logic [KW-1:0]    k;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_wr;
  logic             start_shift, start_mul;

  logic [WIDTH-1:0] sh_nxt;
  logic             sh_out;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  assign accept = bus.in_valid && ready;
  assign a_op   = acc_q[bus.sel];
  assign b_op   = bus.in;
  assign k      = bus.in[KW-1:0];
  assign last   = (cnt_q == CW'(1));

  // Accumulator array; only the addressed slot sees a write.
  for (genvar i = 0; i < NACC; i++) begin : g_acc
    assign acc_we[i] = wr_en && (wr_sel == SW'(i));
    alu_bank_acc #(.WIDTH(WIDTH)) u_acc (
      .clk (clk),
      .rst (rst),
      .we  (acc_we[i]),
      .d   (wr_data),
      .q   (acc_q[i])
    );
  end

  // Single-cycle result and C/V, plus decode of which ops go multi-cycle.
  always_comb begin
    sum         = '0;
    sc_res      = a_op;
    sc_c        = 1'b0;
    sc_v        = 1'b0;
    sc_wr       = 1'b1;
    start_shift = 1'b0;
    start_mul   = 1'b0;
    case (bus.control)
      OP_CLEAR: sc_res = '0;
      OP_ADD, OP_ADC: begin
        sum    = {1'b0, a_op} + {1'b0, b_op}
               + {{WIDTH{1'b0}}, (bus.control == OP_ADC) & flags_q[2]};
        sc_res = sum[M:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a_op[M] == b_op[M]) && (sc_res[M] != a_op[M]);
      end
      OP_SUB: begin
        sc_res = a_op - b_op;
        sc_c   = a_op < b_op;
        sc_v   = (a_op[M] != b_op[M]) && (sc_res[M] != a_op[M]);
      end
      OP_AND:  sc_res = a_op & b_op;
      OP_NEG: begin
        sc_res = '0 - a_op;
        sc_c   = |a_op;
        sc_v   = (a_op == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_NOT:  sc_res = ~a_op;
      OP_XOR:  sc_res = a_op ^ b_op;
      OP_LOAD: sc_res = b_op;
      // k=0 retires immediately with the value unchanged and C=0.
      OP_SHL, OP_SHR: begin
        if (k != '0) begin
          sc_wr       = 1'b0;
          start_shift = 1'b1;
        end
      end
      OP_MUL: begin
        sc_wr     = 1'b0;
        start_mul = 1'b1;
      end
      OP_HOLD: sc_wr = 1'b0;
      default: sc_wr = 1'b0;
    endcase
  end

  // One iteration of the shifter and of the shift-add multiplier.
  always_comb begin
    sh_out  = dir_left_q ? lo_q[M] : lo_q[0];
    sh_nxt  = dir_left_q ? (lo_q << 1) : (lo_q >> 1);
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    hi_nxt  = mul_sum[WIDTH:1];
    lo_nxt  = {mul_sum[0], lo_q[M:1]};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // FSM next state: leave IDLE only for multi-cycle work, return on last step.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (accept && start_shift)    state_nxt = SHIFT;
        else if (accept && start_mul) state_nxt = MUL;
      end
      SHIFT, MUL: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: accumulator/flag write strobes and retire signal.
  always_comb begin
    ready     = (state_q == IDLE);
    wr_en     = 1'b0;
    wr_sel    = sel_q;
    wr_data   = sc_res;
    flags_we  = 1'b0;
    flags_nxt = flags_q;
    fin       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_sel = bus.sel;
          fin    = !(start_shift || start_mul);
          if (sc_wr) begin
            wr_en     = 1'b1;
            flags_we  = 1'b1;
            flags_nxt = {sc_v, sc_c, sc_res[M], sc_res == '0};
          end
        end
      end
      SHIFT: begin
        if (last) begin
          wr_en     = 1'b1;
          wr_data   = sh_nxt;
          flags_we  = 1'b1;
          flags_nxt = {1'b0, sh_out, sh_nxt[M], sh_nxt == '0};
          fin       = 1'b1;
        end
      end
      MUL: begin
        if (last) begin
          wr_en     = 1'b1;
          wr_data   = lo_nxt;
          flags_we  = 1'b1;
          flags_nxt = {1'b0, |hi_nxt, lo_nxt[M], lo_nxt == '0};
          fin       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Status registers: latched select, shared flags, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (accept)   sel_q   <= bus.sel;
      if (flags_we) flags_q <= flags_nxt;
    end
  end

  // Working registers: load at acceptance, step once per busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q       <= '0;
      hi_q       <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      dir_left_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && start_shift) begin
            lo_q       <= a_op;
            cnt_q      <= CW'(k);
            dir_left_q <= (bus.control == OP_SHL);
          end else if (accept && start_mul) begin
            lo_q    <= b_op;
            hi_q    <= '0;
            mcand_q <= a_op;
            cnt_q   <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          lo_q  <= sh_nxt;
          cnt_q <= cnt_q - CW'(1);
        end
        MUL: begin
          lo_q  <= lo_nxt;
          hi_q  <= hi_nxt;
          cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign bus.acc_out  = acc_q[sel_q];
  assign bus.flags    = flags_q;
  assign bus.done     = done_q;
endmodule

// File: doc/alu_bank.md
# alu_bank

Parametrised successor to the single-accumulator ALU. It holds NACC accumulators of WIDTH bits and accepts one command per valid/ready handshake. It keeps the original eight operations and adds LOAD, add-with-carry, and multi-cycle shift and multiply. It sits behind the sequencer as the datapath execution unit and reports completion with a one-cycle `done` pulse.

## Interface
- WIDTH, 8, accumulator and operand width (≥4, power of two)
- NACC, 4, number of accumulators (power of two, ≥2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  command present
- in_ready  out  1  block can accept a command; combinational, high iff state is IDLE
- control  in  4  opcode
- sel  in  $clog2(NACC)  target accumulator
- in  in  WIDTH  operand
- acc_out  out  WIDTH  value of the accumulator addressed by the last accepted command
- flags  out  4  {V,C,N,Z}, bits 3..0; shared by all accumulators
- done  out  1  one-cycle pulse, command retired

## Operation
- A command is accepted on an edge where in_valid && in_ready; control/sel/in are captured, and sel is latched for acc_out.
- Opcodes (A = acc[sel]):
  - 0 HOLD: no change; flags unchanged.
  - 1 CLEAR: A=0.
  - 2 ADD: A+in.
  - 3 SUB: A−in.
  - 4 AND: A&in.
  - 5 NEG: 0−A.
  - 6 NOT: ~A.
  - 7 XOR: A^in.
  - 8 LOAD: A=in.
  - 9 ADC: A+in+C.
  - 10 SHL: logical left shift by k.
  - 11 SHR: logical right shift by k.
  - 12 MUL: low WIDTH bits of A×in, unsigned.
  - 13–15 behave as HOLD.
- Shift amount k = in[$clog2(WIDTH)−1:0].
- Arithmetic is modulo 2^WIDTH. Z = (result==0) and N = result MSB for every opcode except HOLD.
- C and V rules:
  - ADD/ADC: C = carry out; V = signed overflow.
  - SUB: C = borrow (A<in unsigned); V = signed overflow.
  - NEG: C = (A≠0); V = (A==1000…0).
  - SHL/SHR: C = last bit shifted out (0 if k=0); V=0.
  - MUL: C = 1 iff the full product ≥ 2^WIDTH; V=0.
  - CLEAR/AND/NOT/XOR/LOAD: C=V=0.
- State machine IDLE → SHIFT / MUL → IDLE:
  - Single-cycle opcodes and shifts with k=0 complete in IDLE.
  - SHL/SHR with k>0 enter SHIFT and shift one bit per cycle for k iterations.
  - MUL enters MUL and runs shift-add for exactly WIDTH iterations.
- Multi-cycle work uses internal working registers. acc[sel] and flags are written only at completion and hold their old values while busy.
- Only acc[sel] is written; the other accumulators are untouched.

## Timing
- Reset sets all accumulators to 0, flags=0000, latched sel to 0, acc_out=0, done=0 and state to IDLE, so in_ready=1.
- Single-cycle command accepted at edge E: result and flags are written at E, and done is high during cycle E→E+1 with acc_out already updated.
- Multi-cycle command with n iterations (n=k for shifts, n=WIDTH for MUL), accepted at edge E:
  - in_ready is low for n cycles.
  - The result is written at edge E+n.
  - done and in_ready are high in the cycle after E+n.
- Back-to-back single-cycle commands retire one per cycle, so done stays high continuously.
- in_valid while busy is not accepted. The source holds the command until in_ready.
- rst asserted mid-operation aborts the command: no accumulator or flag write, no done pulse, and IDLE on the next cycle.
- rst and in_valid in the same cycle: reset wins and the command is not accepted.
- HOLD and undefined opcodes still produce a done pulse.

## Test plan
All scenarios use WIDTH=8, NACC=4.
- Reset, then ADD 0x05 to acc0, SUB 0x03, SUB 0x03 → acc_out 0x05/flags 0000, then 0x02/0000, then 0xFF/flags 0110 (C=1, N=1); done pulses one cycle after each acceptance.
- LOAD acc1=0x01, ADD 0x7F → 0x80, flags 1010 (V, N); then NEG → 0x80, flags 1110. Subsequent NOT/XOR 0x09/AND 0x0C sequence checked against a reference model; acc0 unchanged throughout.
- LOAD acc2=0x0F, MUL 0x11 → in_ready low exactly 8 cycles, then 0xFF, flags 0010. Then LOAD 0x10, MUL 0x20 → 0x00, flags 0101 (C, Z).
- LOAD acc3=0x81, SHL k=1 → 1 busy cycle, 0x02, C=1. SHR k=7 on 0x80 → 7 busy cycles, 0x01. SHL k=0 → single cycle, value unchanged, C=0.
- ADD 0xFF to 0x01 (C=1), then ADC 0x00 → 0x01 from 0x00+0x00+1. Commands presented while busy are held and accepted only when in_ready rises.
- rst pulsed at the 4th MUL iteration → no done, all accumulators 0, flags 0000, in_ready=1 the next cycle. Opcode 13 → done pulses, state unchanged.
